frame_spi_tx: RTL

FRAME_SPI_TX -- requirements
Module: frame_spi_tx

---
 rtl/lighthouse_pkg.sv | 39 +++
 rtl/spi_clk_div.sv | 48 ++++
 rtl/frame_spi_tx.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lighthouse_pkg.sv
// Shared frame layout and FSM encoding for the lighthouse SPI framer.
package lighthouse_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        START = 3'd2,
        SHIFT = 3'd3,
        GAP   = 3'd4
    } state_e;

    localparam int SLOTS      = 4;
    localparam int WORD_W     = 32;
    localparam int HDR_BITS   = 16;
    localparam int FRAME_BITS = HDR_BITS + SLOTS * WORD_W;   // 144

    // Header field positions within the 16-bit header.
    localparam int HDR_SYNC_LSB = 8;
    localparam int HDR_MASK_LSB = 4;
    localparam int HDR_SEQ_LSB  = 0;

    typedef logic [SLOTS-1:0][WORD_W-1:0] slots_t;

    // Header first, then slot0..slot3; the MSB is the first bit on the wire.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [7:0] sync,
        input logic [3:0] mask,
        input logic [3:0] seq,
        input slots_t     slots
    );
        logic [HDR_BITS-1:0] hdr;
        hdr = '0;
        hdr[HDR_SYNC_LSB +: 8] = sync;
        hdr[HDR_MASK_LSB +: 4] = mask;
        hdr[HDR_SEQ_LSB  +: 4] = seq;
        return {hdr, slots[0], slots[1], slots[2], slots[3]};
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: while enabled, strobes fall/rise alternately every
// CLK_DIV clocks. It assumes SCLK was just driven high when enable rises, so
// the first strobe is a fall.
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       ph_q, ph_d;     // 1: SCLK currently high
    logic       tc;

    // Half-period counter and phase tracking; idles at count 0, phase high.
    always_comb begin
        tc    = (cnt_q == HALF_LAST);
        cnt_d = cnt_q + 8'd1;
        ph_d  = ph_q;
        if (!en_i) begin
            cnt_d = '0;
            ph_d  = 1'b1;
        end else if (tc) begin
            cnt_d = '0;
            ph_d  = ~ph_q;
        end
    end

    assign rise_o = en_i & tc & ~ph_q;
    assign fall_o = en_i & tc &  ph_q;

    // Divider state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ph_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

endmodule

// File: rtl/frame_spi_tx.sv
// Collects up to four 32-bit words and ships them as one 144-bit SPI frame
// (mode 0, MSB first) with a sync/mask/sequence header.
module frame_spi_tx
    import lighthouse_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] word_i,
    input  logic        word_valid_i,
    output logic        word_ready_o,
    input  logic        flush_i,
    output logic        spi_sclk_o,
    output logic        spi_mosi_o,
    output logic        spi_ss_n_o,
    output logic        busy_o
);

    localparam logic [8:0] START_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_LAST   = 9'(2 * CLK_DIV - 1);
    localparam logic [7:0] BIT_LAST   = 8'(FRAME_BITS - 1);

    state_e                  state_q, state_d;
    logic [8:0]              cnt_q, cnt_d;
    logic [7:0]              bit_q, bit_d;
    logic                    sclk_q, sclk_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    slots_t                  slots_q, slots_d;
    logic [2:0]              fill_q, fill_d;
    logic [3:0]              mask_q, mask_d;
    logic [3:0]              seq_q, seq_d;
    logic                    accept;
    logic                    sclk_rise, sclk_fall;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == SHIFT),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    // Ready depends only on state and fill level so the source may wait on it.
    assign word_ready_o = (state_q == FILL) && (fill_q < 3'd4);
    assign accept       = word_ready_o && word_valid_i;
    assign busy_o       = (state_q == START) || (state_q == SHIFT) || (state_q == GAP);
    assign spi_ss_n_o   = !((state_q == START) || (state_q == SHIFT));
    assign spi_sclk_o   = sclk_q;
    assign spi_mosi_o   = sr_q[FRAME_BITS-1];

    // Next-state logic: fill the buffer, then frame/shift/gap sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        sr_d    = sr_q;
        slots_d = slots_q;
        fill_d  = fill_q;
        mask_d  = mask_q;
        seq_d   = seq_q;
        unique case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                if (accept) begin
                    slots_d[fill_q[1:0]] = word_i;
                    mask_d[fill_q[1:0]]  = 1'b1;
                    fill_d               = fill_q + 3'd1;
                end
                // A flush on the 4th-word cycle is simply a full frame.
                if ((accept && fill_q == 3'd3) || (flush_i && fill_q != 3'd0)) begin
                    state_d = START;
                    cnt_d   = '0;
                    sr_d    = build_frame(SYNC_BYTE, mask_d, seq_q, slots_d);
                end
            end
            START: begin
                // SS low with SCLK low for one half-period, then first rise.
                if (cnt_q == START_LAST) begin
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            SHIFT: begin
                if (sclk_rise) sclk_d = 1'b1;
                if (sclk_fall) begin
                    sclk_d = 1'b0;
                    sr_d   = {sr_q[FRAME_BITS-2:0], 1'b0};
                    bit_d  = bit_q + 8'd1;
                    if (bit_q == BIT_LAST) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = FILL;
                    fill_d  = '0;
                    mask_d  = '0;
                    slots_d = '0;
                    seq_d   = seq_q + 4'd1;
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            sr_q    <= '0;
            slots_q <= '0;
            fill_q  <= '0;
            mask_q  <= '0;
            seq_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            sr_q    <= sr_d;
            slots_q <= slots_d;
            fill_q  <= fill_d;
            mask_q  <= mask_d;
            seq_q   <= seq_d;
        end
    end

endmodule
